// File: rtl/demux_serial_sequencer.sv
// Serialises an 8-bit word onto a 1-to-8 demux: steps sel through the masked
// channels lowest first, holding each channel's select/bit/strobe for HOLD cycles.
module demux_serial_sequencer #(
   parameter int HOLD = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] word_i,
   input  logic [7:0] mask_i,
   input  logic       word_valid,
   output logic       word_ready,
   output logic [2:0] sel,
   output logic       bit_o,
   output logic       strobe,
   output logic       busy,
   output logic       done
);

   // Handshake: a word transfers on a rising edge where word_valid and word_ready
   // are both high; word_ready is high only in IDLE and does not depend on word_valid.
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

   state_t     state, state_n;
   logic [7:0] word_r, word_n;
   logic [7:0] mask_r, mask_n;
   logic [2:0] ptr, ptr_n;
   logic [3:0] hold_cnt, hold_n;
   logic [2:0] sel_n;
   logic       bit_n, strobe_n, busy_n, done_n;
   logic [2:0] first_idx, next_idx;
   logic       next_found;

   assign word_ready = (state == IDLE);

   // Scanning downward leaves the lowest qualifying index in each result.
   always_comb begin
      first_idx  = '0;
      next_idx   = '0;
      next_found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_i[i]) first_idx = 3'(i);
         if (mask_r[i] && (i > int'(ptr))) begin
            next_idx   = 3'(i);
            next_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n  = state;
      word_n   = word_r;
      mask_n   = mask_r;
      ptr_n    = ptr;
      hold_n   = hold_cnt;
      sel_n    = '0;
      bit_n    = 1'b0;
      strobe_n = 1'b0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (word_valid) begin
               word_n = word_i;
               mask_n = mask_i;
               hold_n = '0;
               busy_n = 1'b1;
               if (mask_i != 8'h00) begin
                  state_n  = SEND;
                  ptr_n    = first_idx;
                  strobe_n = 1'b1;
                  sel_n    = first_idx;
                  bit_n    = word_i[first_idx];
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end
         end
         SEND: begin
            busy_n = 1'b1;
            if (hold_cnt == HOLD_LAST) begin
               hold_n = '0;
               if (next_found) begin
                  ptr_n    = next_idx;
                  strobe_n = 1'b1;
                  sel_n    = next_idx;
                  bit_n    = word_r[next_idx];
               end else begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end
            end else begin
               hold_n   = hold_cnt + 4'd1;
               strobe_n = 1'b1;
               sel_n    = ptr;
               bit_n    = word_r[ptr];
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         word_r   <= '0;
         mask_r   <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
         sel      <= '0;
         bit_o    <= 1'b0;
         strobe   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         word_r   <= word_n;
         mask_r   <= mask_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         sel      <= sel_n;
         bit_o    <= bit_n;
         strobe   <= strobe_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule
